// File: rtl/pn_pkg.sv
// Shared definitions for the PN generator/checker pair: register length limits,
// checker state encoding and helpers for the active-length mask.
package pn_pkg;

  localparam int PN_MAX_LEN = 13;
  localparam int PN_N_MIN   = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    LOCKED
  } pn_state_t;

  // Bits [n-1:0] set; lengths beyond the register width saturate to all ones.
  function automatic logic [PN_MAX_LEN-1:0] len_mask(input logic [3:0] n);
    logic [PN_MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < PN_MAX_LEN; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic len_legal(input logic [3:0] n);
    return (n >= 4'(PN_N_MIN)) && (n <= 4'(PN_MAX_LEN));
  endfunction

endpackage

// File: rtl/pn_feedback.sv
// LFSR feedback parity: XOR of the state bits selected by the polynomial taps,
// restricted to the active register length. Shared by generator and checker.
module pn_feedback
  import pn_pkg::*;
(
  input  logic [PN_MAX_LEN-1:0] state,
  input  logic [PN_MAX_LEN-1:0] char_poly,
  input  logic [3:0]            n,
  output logic                  fb
);

  assign fb = ^(state & char_poly & len_mask(n));

endmodule

// File: rtl/pn_seq_checker.sv
// PN sequence checker: self-synchronises a local LFSR to the received stream,
// verifies lock, then flywheels on its own prediction and counts bit errors,
// dropping sync when a window collects too many errors.
module pn_seq_checker
  import pn_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int WIN_LEN   = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic [3:0]            N,
  input  logic [PN_MAX_LEN-1:0] char_poly,
  input  logic                  clr_cnt,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  loss_pulse,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int OK_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W = $clog2(WIN_LEN + 1);

  pn_state_t             state, state_nxt;
  logic [PN_MAX_LEN-1:0] r, r_nxt;
  logic [3:0]            n_sh, n_sh_nxt;
  logic [PN_MAX_LEN-1:0] poly_sh, poly_sh_nxt;
  logic [3:0]            ld_cnt, ld_cnt_nxt, ld_inc;
  logic [OK_W-1:0]       ok_cnt, ok_cnt_nxt;
  logic [WIN_W-1:0]      win_cnt, win_cnt_nxt;
  logic [WIN_W-1:0]      win_err, win_err_nxt, win_err_inc;
  logic [CNT_W-1:0]      err_count_nxt, bit_count_nxt;
  logic                  err_nxt, loss_nxt;
  logic                  pred, mism, cfg_changed;
  logic [PN_MAX_LEN-1:0] r_ld, r_fw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Shift toward bit 0, insert b at the top of the active length, clear the rest.
  function automatic logic [PN_MAX_LEN-1:0] shift_in(
    input logic [PN_MAX_LEN-1:0] cur,
    input logic                  b,
    input logic [3:0]            n
  );
    logic [PN_MAX_LEN-1:0] res;
    res = (cur >> 1) & len_mask(n - 4'd1);
    for (int i = 0; i < PN_MAX_LEN; i++) begin
      if (i == int'(n) - 1) res[i] = b;
    end
    return res;
  endfunction

  pn_feedback u_feedback (
    .state     (r),
    .char_poly (poly_sh),
    .n         (n_sh),
    .fb        (pred)
  );

  assign mism        = (bit_in != pred);
  assign r_ld        = shift_in(r, bit_in, n_sh);
  assign r_fw        = shift_in(r, pred, n_sh);
  assign ld_inc      = (ld_cnt == n_sh) ? ld_cnt : ld_cnt + 4'd1;
  assign win_err_inc = win_err + WIN_W'(mism);
  // Taps above the active length are don't-care, so only the masked polynomial counts as a change.
  assign cfg_changed = (N != n_sh) ||
                       ((char_poly & len_mask(N)) != (poly_sh & len_mask(n_sh)));

  // Next-state, counter and output decode; only valid bits advance the sequence.
  always_comb begin
    state_nxt     = state;
    r_nxt         = r;
    n_sh_nxt      = n_sh;
    poly_sh_nxt   = poly_sh;
    ld_cnt_nxt    = ld_cnt;
    ok_cnt_nxt    = ok_cnt;
    win_cnt_nxt   = win_cnt;
    win_err_nxt   = win_err;
    err_count_nxt = err_count;
    bit_count_nxt = bit_count;
    err_nxt       = 1'b0;
    loss_nxt      = 1'b0;

    if (state == IDLE) begin
      if (len_legal(N)) begin
        state_nxt   = LOAD;
        n_sh_nxt    = N;
        poly_sh_nxt = char_poly;
        ld_cnt_nxt  = '0;
      end
    end else if (cfg_changed) begin
      // Resynchronise on the new configuration; an illegal length parks in IDLE.
      loss_nxt    = (state == LOCKED);
      n_sh_nxt    = N;
      poly_sh_nxt = char_poly;
      ld_cnt_nxt  = '0;
      state_nxt   = len_legal(N) ? LOAD : IDLE;
    end else if (bit_valid) begin
      case (state)
        LOAD: begin
          r_nxt      = r_ld;
          ld_cnt_nxt = ld_inc;
          if ((ld_inc == n_sh) && ((r_ld & len_mask(n_sh)) != '0)) begin
            state_nxt  = VERIFY;
            ok_cnt_nxt = '0;
          end
        end
        VERIFY: begin
          r_nxt = r_ld;
          if (!mism) begin
            ok_cnt_nxt = ok_cnt + 1'b1;
            if (ok_cnt == OK_W'(LOCK_CNT - 1)) begin
              state_nxt   = LOCKED;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end
          end else begin
            state_nxt  = LOAD;
            ld_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          r_nxt         = r_fw;
          bit_count_nxt = sat_inc(bit_count);
          if (mism) begin
            err_nxt       = 1'b1;
            err_count_nxt = sat_inc(err_count);
          end
          if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
            if (win_err_inc >= WIN_W'(LOSS_ERRS)) begin
              state_nxt  = LOAD;
              ld_cnt_nxt = '0;
              loss_nxt   = 1'b1;
            end
          end else begin
            win_cnt_nxt = win_cnt + 1'b1;
            win_err_nxt = win_err_inc;
          end
        end
        default: ;
      endcase
    end

    if (clr_cnt) begin
      err_count_nxt = '0;
      bit_count_nxt = '0;
    end
  end

  // State, local LFSR, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r          <= '0;
      n_sh       <= '0;
      poly_sh    <= '0;
      ld_cnt     <= '0;
      ok_cnt     <= '0;
      win_cnt    <= '0;
      win_err    <= '0;
      err_count  <= '0;
      bit_count  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      loss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      r          <= r_nxt;
      n_sh       <= n_sh_nxt;
      poly_sh    <= poly_sh_nxt;
      ld_cnt     <= ld_cnt_nxt;
      ok_cnt     <= ok_cnt_nxt;
      win_cnt    <= win_cnt_nxt;
      win_err    <= win_err_nxt;
      err_count  <= err_count_nxt;
      bit_count  <= bit_count_nxt;
      locked     <= (state_nxt == LOCKED);
      err_pulse  <= err_nxt;
      loss_pulse <= loss_nxt;
    end
  end

endmodule
